// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch path.
//   fetch_state_e : sequencer state (IDLE, RUN, DRAIN, FAULT)
//   INSTR_BYTES   : bytes per instruction word
//   ALIGN_MASK    : low address bits that must be zero for a word fetch
//   state_is_busy : true while the sequencer owns an active fetch stream
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES = 32'd4;
   localparam logic [1:0]  ALIGN_MASK  = 2'b11;

   function automatic logic state_is_busy(input fetch_state_e st);
      return (st == RUN) || (st == DRAIN);
   endfunction

endpackage

// File: rtl/fetch_range_check.sv
// fetch_range_check: combinational legality check for a word access.
//   addr         in  : byte address of the first byte of the word
//   mem_bytes    in  : size of the target memory in bytes
//   misaligned   out : addr is not a multiple of the word size
//   out_of_range out : last byte of the word (addr+3) lies beyond mem_bytes-1
module fetch_range_check
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] mem_bytes,
   output logic              misaligned,
   output logic              out_of_range
);

   // One extra bit so addr+3 near the top of the address space cannot wrap.
   logic [ADDR_W:0] last_byte_s;

   // Alignment and bounds evaluation; addr+3 > mem_bytes-1 is written as
   // addr+3 >= mem_bytes so mem_bytes==0 needs no special case.
   always_comb begin
      last_byte_s  = {1'b0, addr} + (ADDR_W+1)'(INSTR_BYTES - 32'd1);
      misaligned   = (addr[1:0] & ALIGN_MASK) != 2'b00;
      out_of_range = last_byte_s >= {1'b0, mem_bytes};
   end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives a synchronous-read (1-cycle latency) instruction
// memory and hands fetched words to decode over a valid/ready handshake.
//   clk, reset          : clock, synchronous active-high reset
//   start / halt_req    : begin fetching / stop issuing and drain to IDLE
//   redirect_valid/_pc  : taken branch target, squashes the in-flight word
//   mem_addr, mem_instr : memory address out, registered read data in
//   instr_valid/_ready  : decode handshake; instr, instr_pc carry the word
//   busy                : sequencer in RUN or DRAIN
//   fault, fault_addr   : sticky illegal-fetch flag and offending address
//   fetch_count         : number of accepted handshakes (wraps)
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int              ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int              MEM_BYTES = 501
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              halt_req,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              busy,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_addr,
   output logic [31:0]       fetch_count
);

   fetch_state_e      state_r, state_n;
   logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_n;
   logic              inflight_valid_r, inflight_valid_n;
   logic [ADDR_W-1:0] inflight_pc_r, inflight_pc_n;
   logic              fault_r, fault_n;
   logic [ADDR_W-1:0] fault_addr_r, fault_addr_n;
   logic [31:0]       fetch_count_r;

   logic              stall_s;
   logic              accept_s;
   logic              do_issue_s;
   logic [ADDR_W-1:0] issue_addr_s;
   logic              misaligned_s;
   logic              out_of_range_s;

   // A redirect always issues its own target; otherwise the next sequential PC.
   assign issue_addr_s = redirect_valid ? redirect_pc : fetch_pc_r;

   fetch_range_check #(.ADDR_W(ADDR_W)) u_range (
      .addr        (issue_addr_s),
      .mem_bytes   (ADDR_W'(MEM_BYTES)),
      .misaligned  (misaligned_s),
      .out_of_range(out_of_range_s)
   );

   // State and PC registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r          <= IDLE;
         fetch_pc_r       <= RESET_PC;
         inflight_valid_r <= 1'b0;
         inflight_pc_r    <= '0;
         fault_r          <= 1'b0;
         fault_addr_r     <= '0;
      end else begin
         state_r          <= state_n;
         fetch_pc_r       <= fetch_pc_n;
         inflight_valid_r <= inflight_valid_n;
         inflight_pc_r    <= inflight_pc_n;
         fault_r          <= fault_n;
         fault_addr_r     <= fault_addr_n;
      end
   end

   // Accepted-handshake counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count_r <= 32'd0;
      end else if (accept_s) begin
         fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
         fetch_count_r <= fetch_count_r;
      end
   end

   // Next-state logic: priority is redirect > halt_req > issue.
   always_comb begin
      state_n          = state_r;
      fetch_pc_n       = fetch_pc_r;
      inflight_valid_n = inflight_valid_r;
      inflight_pc_n    = inflight_pc_r;
      fault_n          = fault_r;
      fault_addr_n     = fault_addr_r;
      do_issue_s       = 1'b0;
      case (state_r)
         IDLE: begin
            inflight_valid_n = 1'b0;
            // IDLE redirect only retargets; nothing is fetched so nothing is checked.
            if (redirect_valid) begin
               fetch_pc_n = redirect_pc;
            end else begin
               fetch_pc_n = fetch_pc_r;
            end
            if (start) begin
               state_n = RUN;
            end else begin
               state_n = IDLE;
            end
         end
         RUN, DRAIN: begin
            if (redirect_valid && halt_req) begin
               fetch_pc_n       = redirect_pc;
               inflight_valid_n = 1'b0;
               state_n          = IDLE;
            end else if (redirect_valid) begin
               do_issue_s = 1'b1;
            end else if (state_r == DRAIN) begin
               if (accept_s) begin
                  inflight_valid_n = 1'b0;
                  state_n          = IDLE;
               end else begin
                  state_n = DRAIN;
               end
            end else if (halt_req) begin
               if (stall_s) begin
                  state_n = DRAIN;
               end else begin
                  inflight_valid_n = 1'b0;
                  state_n          = IDLE;
               end
            end else if (stall_s) begin
               state_n = RUN;
            end else begin
               do_issue_s = 1'b1;
            end

            if (do_issue_s) begin
               if (misaligned_s || out_of_range_s) begin
                  fault_n          = 1'b1;
                  fault_addr_n     = issue_addr_s;
                  inflight_valid_n = 1'b0;
                  state_n          = FAULT;
               end else begin
                  inflight_valid_n = 1'b1;
                  inflight_pc_n    = issue_addr_s;
                  fetch_pc_n       = issue_addr_s + ADDR_W'(INSTR_BYTES);
                  state_n          = RUN;
               end
            end else begin
               inflight_pc_n = inflight_pc_r;
            end
         end
         FAULT: begin
            state_n = FAULT;
         end
         default: begin
            inflight_valid_n = 1'b0;
            state_n          = FAULT;
         end
      endcase
   end

   // Output and handshake decode.
   always_comb begin
      busy        = state_is_busy(state_r);
      instr_valid = inflight_valid_r & ~redirect_valid & busy;
      accept_s    = instr_valid & instr_ready;
      stall_s     = inflight_valid_r & ~instr_ready;
      // A redirect in RUN/DRAIN overrides the stall hold: the target is what
      // gets issued, so it must be what the memory reads. Outside RUN/DRAIN
      // nothing is in flight, so stall cannot be set there.
      if (redirect_valid) begin
         mem_addr = redirect_pc;
      end else if (stall_s) begin
         mem_addr = inflight_pc_r;
      end else begin
         mem_addr = fetch_pc_r;
      end
   end

   assign instr       = mem_instr;
   assign instr_pc    = inflight_pc_r;
   assign fault       = fault_r;
   assign fault_addr  = fault_addr_r;
   assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios against fetch_sequencer with a
// 501-byte big-endian synchronous-read memory model.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [31:0] mem_addr;
   logic [31:0] mem_instr = 32'd0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        busy;
   logic        fault;
   logic [31:0] fault_addr;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:500];

   fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'd0), .MEM_BYTES(501)) dut (
      .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_addr(mem_addr), .mem_instr(mem_instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .busy(busy), .fault(fault), .fault_addr(fault_addr), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rd(input logic [31:0] a);
      if (a < 32'd501) return mem[a];
      else return 8'h00;
   endfunction

   // Synchronous read, big-endian byte order.
   always @(posedge clk) begin
      mem_instr <= {rd(mem_addr), rd(mem_addr + 32'd1), rd(mem_addr + 32'd2), rd(mem_addr + 32'd3)};
   end

   // Expected byte pattern written independently of the memory array.
   function automatic logic [7:0] eb(input int i);
      return 8'((i * 7 + 3) & 255);
   endfunction

   function automatic logic [31:0] ew(input int a);
      return {eb(a), eb(a + 1), eb(a + 2), eb(a + 3)};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; halt_req = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b exp 0", fault); end
      checks++; if (fault_addr !== 32'd0) begin errors++; $display("FAIL reset_fault_addr got %h exp 0", fault_addr); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
      checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
   endtask

   task automatic test_stream();
      do_reset();
      start = 1'b1; instr_ready = 1'b1; #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_c0_valid got %0b exp 0", instr_valid); end
      @(negedge clk); start = 1'b0; #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_c1_busy got %0b exp 1", busy); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got %0b exp 0", instr_valid); end
      checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL stream_c1_mem_addr got %h exp 0", mem_addr); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got %0b exp 1", k, instr_valid); end
         checks++; if (instr_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc got %h exp %h", instr_pc, 4 * k); end
         checks++; if (instr !== ew(4 * k)) begin errors++; $display("FAIL stream_instr got %h exp %h", instr, ew(4 * k)); end
         checks++; if (mem_addr !== 32'(4 * k + 4)) begin errors++; $display("FAIL stream_mem_addr got %h exp %h", mem_addr, 4 * k + 4); end
      end
      @(negedge clk); #1;
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL stream_count got %0d exp 4", fetch_count); end
   endtask

   task automatic test_backpressure();
      do_reset();
      start = 1'b1; instr_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); instr_ready = 1'b0; #1;
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid k=%0d got %0b exp 1", k, instr_valid); end
         checks++; if (instr_pc !== 32'd8) begin errors++; $display("FAIL bp_pc got %h exp 8", instr_pc); end
         checks++; if (instr !== ew(8)) begin errors++; $display("FAIL bp_instr got %h exp %h", instr, ew(8)); end
         checks++; if (mem_addr !== 32'd8) begin errors++; $display("FAIL bp_mem_addr got %h exp 8", mem_addr); end
      end
      @(negedge clk); instr_ready = 1'b1; #1;
      checks++; if (instr_pc !== 32'd8 || instr_valid !== 1'b1) begin errors++; $display("FAIL bp_release_pc got %h/%0b exp 8/1", instr_pc, instr_valid); end
      checks++; if (mem_addr !== 32'd12) begin errors++; $display("FAIL bp_release_mem_addr got %h exp c", mem_addr); end
      checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL bp_count_stall got %0d exp 2", fetch_count); end
      @(negedge clk); #1;
      checks++; if (instr_pc !== 32'd12 || instr !== ew(12)) begin errors++; $display("FAIL bp_next got %h/%h exp c/%h", instr_pc, instr, ew(12)); end
      @(negedge clk); #1;
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", fetch_count); end
      checks++; if (instr_pc !== 32'd16) begin errors++; $display("FAIL bp_pc_after got %h exp 10", instr_pc); end
   endtask

   task automatic test_redirect();
      do_reset();
      start = 1'b1; instr_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_squash got %0b exp 0", instr_valid); end
      checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL redir_mem_addr got %h exp 40", mem_addr); end
      @(negedge clk); redirect_valid = 1'b0; #1;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin errors++; $display("FAIL redir_target got %0b/%h exp 1/40", instr_valid, instr_pc); end
      checks++; if (instr !== ew(32'h40)) begin errors++; $display("FAIL redir_instr got %h exp %h", instr, ew(32'h40)); end
      @(negedge clk); #1;
      checks++; if (instr_pc !== 32'h44) begin errors++; $display("FAIL redir_next got %h exp 44", instr_pc); end
      @(negedge clk); #1;
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL redir_count got %0d exp 4", fetch_count); end
   endtask

   task automatic test_halt();
      do_reset();
      start = 1'b1; instr_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); instr_ready = 1'b0; halt_req = 1'b1; #1;
      checks++; if (instr_pc !== 32'd12 || instr_valid !== 1'b1) begin errors++; $display("FAIL halt_stall_pc got %h/%0b exp c/1", instr_pc, instr_valid); end
      @(negedge clk); halt_req = 1'b0; #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL halt_drain_busy got %0b exp 1", busy); end
      checks++; if (mem_addr !== 32'd12 || instr_pc !== 32'd12) begin errors++; $display("FAIL halt_drain_hold got %h/%h exp c/c", mem_addr, instr_pc); end
      @(negedge clk); instr_ready = 1'b1; #1;
      checks++; if (instr_valid !== 1'b1 || instr !== ew(12)) begin errors++; $display("FAIL halt_drain_word got %0b/%h exp 1/%h", instr_valid, instr, ew(12)); end
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_idle got %0b/%0b exp 0/0", busy, instr_valid); end
      @(negedge clk); #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_quiet got %0b exp 0", instr_valid); end
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL halt_count got %0d exp 4", fetch_count); end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; #1;
      checks++; if (mem_addr !== 32'd16 || busy !== 1'b1) begin errors++; $display("FAIL halt_resume_addr got %h/%0b exp 10/1", mem_addr, busy); end
      @(negedge clk); #1;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd16) begin errors++; $display("FAIL halt_resume_pc got %0b/%h exp 1/10", instr_valid, instr_pc); end
   endtask

   task automatic test_bounds();
      do_reset();
      start = 1'b1; instr_ready = 1'b1;
      @(negedge clk); start = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd496; #1;
      checks++; if (mem_addr !== 32'd496) begin errors++; $display("FAIL bnd_mem_addr got %0d exp 496", mem_addr); end
      @(negedge clk); redirect_valid = 1'b0; #1;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd496) begin errors++; $display("FAIL bnd_last_pc got %0b/%0d exp 1/496", instr_valid, instr_pc); end
      checks++; if (instr !== ew(496)) begin errors++; $display("FAIL bnd_last_instr got %h exp %h", instr, ew(496)); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL bnd_no_fault got %0b exp 0", fault); end
      @(negedge clk); start = 1'b1; #1;
      checks++; if (fault !== 1'b1 || fault_addr !== 32'd500) begin errors++; $display("FAIL bnd_fault got %0b/%0d exp 1/500", fault, fault_addr); end
      checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL bnd_fault_idle got %0b/%0b exp 0/0", busy, instr_valid); end
      @(negedge clk); start = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd0; #1;
      checks++; if (busy !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL bnd_start_ignored got %0b/%0b exp 0/1", busy, fault); end
      @(negedge clk); redirect_valid = 1'b0; #1;
      checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || fault_addr !== 32'd500) begin errors++; $display("FAIL bnd_sticky got %0b/%0b/%0d exp 0/0/500", busy, instr_valid, fault_addr); end
      checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL bnd_count got %0d exp 1", fetch_count); end
      do_reset(); #1;
      checks++; if (fault !== 1'b0 || fault_addr !== 32'd0) begin errors++; $display("FAIL bnd_reset_clear got %0b/%h exp 0/0", fault, fault_addr); end
   endtask

   task automatic test_misaligned();
      do_reset();
      start = 1'b1; instr_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h42; #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_squash got %0b exp 0", instr_valid); end
      @(negedge clk); redirect_valid = 1'b0; #1;
      checks++; if (fault !== 1'b1 || fault_addr !== 32'h42) begin errors++; $display("FAIL mis_fault got %0b/%h exp 1/42", fault, fault_addr); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mis_quiet k=%0d got %0b/%0b exp 0/0", k, instr_valid, busy); end
      end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL mis_count got %0d exp 0", fetch_count); end
   endtask

   task automatic test_idle_redirect();
      do_reset();
      start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20; instr_ready = 1'b1; #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_redir_valid got %0b exp 0", instr_valid); end
      @(negedge clk); start = 1'b0; redirect_valid = 1'b0; #1;
      checks++; if (mem_addr !== 32'h20 || busy !== 1'b1) begin errors++; $display("FAIL idle_redir_addr got %h/%0b exp 20/1", mem_addr, busy); end
      @(negedge clk); #1;
      checks++; if (instr_pc !== 32'h20 || instr !== ew(32'h20)) begin errors++; $display("FAIL idle_redir_word got %h/%h exp 20/%h", instr_pc, instr, ew(32'h20)); end
   endtask

   task automatic test_reset_midstall();
      do_reset();
      start = 1'b1; instr_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); instr_ready = 1'b0;
      @(negedge clk);
      @(negedge clk); reset = 1'b1; instr_ready = 1'b1;
      @(negedge clk);
      @(negedge clk); reset = 1'b0; instr_ready = 1'b0; #1;
      checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_stall_drop got %0b/%0b exp 0/0", instr_valid, busy); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rst_stall_count got %0d exp 0", fetch_count); end
   endtask

   initial begin
      for (int i = 0; i < 501; i++) mem[i] = 8'((i * 7 + 3) & 255);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_bounds();
      test_misaligned();
      test_idle_redirect();
      test_reset_midstall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
